// File: rtl/cache_adaptor_pkg.sv
// Shared types for the cache-line <-> memory-burst adaptor.
// Holds the adaptor state encoding and the default width parameters.
// No logic; imported by param_cacheline_adaptor.
package cache_adaptor_pkg;

  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int ADDR_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/param_cacheline_adaptor.sv
// Purpose: moves one LINE_W-bit cache line to/from memory as BEATS = LINE_W/BURST_W
//   beats, each beat qualified by resp_i so memory may stall between beats.
// Ports: LLC side  - line_i, line_o, address_i, read_i, write_i, resp_o
//        Mem side  - burst_i, burst_o, address_o, read_o, write_o, resp_i
//        clk, reset_n (synchronous, active-low)
// Option: define PARAM_CACHELINE_ADAPTOR_WRAP_EN for critical-beat-first wrapped reads.
// Latency: strobe from the cycle after the request; resp_o one cycle after the last
//   acknowledged beat; every stalled beat cycle adds one cycle.
module param_cacheline_adaptor
  import cache_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int LINE_OFF = $clog2(LINE_W / 8);
  localparam int BEAT_OFF = $clog2(BURST_W / 8);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   N_ONE   = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0]   N_LAST  = (CNT_W + 1)'(BEATS - 1);

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W:0]                 r_n;
  logic [BEATS-1:0][BURST_W-1:0]  r_line;
  logic [BURST_W-1:0]             r_burst;
  logic [ADDR_W-1:0]              r_addr;
  logic                           r_read;
  logic                           r_write;
  logic                           r_resp;

  logic [ADDR_W-1:0] w_line_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [CNT_W-1:0]  w_rd_start;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_last;

  assign w_line_addr = address_i & ({ADDR_W{1'b1}} << LINE_OFF);

`ifdef PARAM_CACHELINE_ADAPTOR_WRAP_EN
  // Reads fetch the requested beat first; memory walks the line from there and wraps.
  assign w_rd_addr  = address_i & ({ADDR_W{1'b1}} << BEAT_OFF);
  assign w_rd_start = address_i[LINE_OFF-1:BEAT_OFF];
`else
  assign w_rd_addr  = w_line_addr;
  assign w_rd_start = '0;
`endif

  assign w_cnt_nxt = r_cnt + CNT_ONE;   // wraps mod BEATS by width
  assign w_last    = (r_n == N_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_line  <= '0;
      r_burst <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_state <= RBURST;
            r_addr  <= w_rd_addr;
            r_cnt   <= w_rd_start;
            r_n     <= '0;
            r_read  <= 1'b1;
          end else if (write_i) begin
            r_state <= WBURST;
            r_addr  <= w_line_addr;
            r_cnt   <= '0;
            r_n     <= '0;
            r_line  <= line_i;
            r_burst <= line_i[BURST_W-1:0];
            r_write <= 1'b1;
          end
        end
        RBURST: begin
          if (resp_i) begin
            r_line[r_cnt] <= burst_i;
            r_cnt         <= w_cnt_nxt;
            r_n           <= r_n + N_ONE;
            if (w_last) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WBURST: begin
          if (resp_i) begin
            r_cnt <= w_cnt_nxt;
            r_n   <= r_n + N_ONE;
            if (w_last) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              // Next beat is presented only once the current one is acknowledged.
              r_burst <= r_line[w_cnt_nxt];
            end
          end
        end
        DONE: begin
          // Always return to IDLE so the still-held request is not re-accepted here.
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign line_o    = r_line;
  assign burst_o   = r_burst;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;

endmodule

// File: tb/tb_param_cacheline_adaptor.sv
// Scoreboard bench for param_cacheline_adaptor at default widths (256/64/32).
// Requests push expected line/address/completion cycle; a negedge monitor pops on resp_o.
// Write beats are queued and checked against burst_o every cycle write_o is high.
module tb_param_cacheline_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  localparam logic [BURST_W-1:0] BA = 64'hAAAA_0000_1111_000A;
  localparam logic [BURST_W-1:0] BB = 64'hBBBB_2222_3333_000B;
  localparam logic [BURST_W-1:0] BC = 64'hCCCC_4444_5555_000C;
  localparam logic [BURST_W-1:0] BD = 64'hDDDD_6666_7777_000D;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  param_cacheline_adaptor #(
    .LINE_W (LINE_W),
    .BURST_W(BURST_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit no_write = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                is_read;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] addr;
    int                done_cyc;
  } txn_t;

  txn_t               sb_q[$];
  logic [BURST_W-1:0] beat_q[$];

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: write beats and completions, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (write_o) begin
        if (no_write) check_eq("write_o_forbidden", LINE_W'(write_o), '0);
        check_eq("write_beat_pending", LINE_W'(beat_q.size() != 0), LINE_W'(1));
        if (beat_q.size() != 0) begin
          check_eq("burst_o", LINE_W'(burst_o), LINE_W'(beat_q[0]));
          if (resp_i) void'(beat_q.pop_front());
        end
      end
      if (resp_o) begin
        check_eq("resp_expected", LINE_W'(sb_q.size() != 0), LINE_W'(1));
        if (sb_q.size() != 0) begin
          txn_t t;
          t = sb_q.pop_front();
          check_eq("resp_cycle", LINE_W'(cyc), LINE_W'(t.done_cyc));
          check_eq("address_o", LINE_W'(address_o), LINE_W'(t.addr));
          check_eq("strobes_low_at_resp", LINE_W'({read_o, write_o}), '0);
          if (t.is_read) check_eq("line_o", line_o, t.line);
        end
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] addr,
                         input logic [BEATS-1:0][BURST_W-1:0] beats,
                         input int stall_at, input int stalls, input bit also_write);
    txn_t              t;
    int                s;
    logic [LINE_W-1:0] exp_line;
`ifdef PARAM_CACHELINE_ADAPTOR_WRAP_EN
    s      = int'(addr[4:3]);
    t.addr = addr & ~32'h7;
`else
    s      = 0;
    t.addr = addr & ~32'h1F;
`endif
    exp_line = '0;
    for (int i = 0; i < BEATS; i++)
      exp_line[((s + i) % BEATS) * BURST_W +: BURST_W] = beats[i];
    t.is_read = 1'b1;
    t.line    = exp_line;
    read_i    = 1'b1;
    write_i   = also_write;
    line_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    address_i = addr;
    tick();
    t.done_cyc = cyc + BEATS + stalls;
    sb_q.push_back(t);
    check_eq("read_o_rise", LINE_W'(read_o), LINE_W'(1));
    for (int i = 0; i < BEATS; i++) begin
      if (i == stall_at) begin
        resp_i = 1'b0;
        repeat (stalls) tick();
      end
      resp_i  = 1'b1;
      burst_i = beats[i];
      tick();
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
    check_eq("read_retired", LINE_W'(sb_q.size()), '0);
    check_eq("resp_o_one_cycle", LINE_W'(resp_o), '0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr,
                          input logic [BEATS-1:0][BURST_W-1:0] line,
                          input int stall_at, input int stalls);
    txn_t t;
    t.is_read = 1'b0;
    t.line    = line;
    t.addr    = addr & ~32'h1F;
    for (int i = 0; i < BEATS; i++) beat_q.push_back(line[i]);
    write_i   = 1'b1;
    line_i    = line;
    address_i = addr;
    tick();
    t.done_cyc = cyc + BEATS + stalls;
    sb_q.push_back(t);
    check_eq("write_o_rise", LINE_W'(write_o), LINE_W'(1));
    for (int i = 0; i < BEATS; i++) begin
      if (i == stall_at) begin
        resp_i = 1'b0;
        repeat (stalls) tick();
      end
      resp_i  = 1'b1;
      burst_i = $urandom;
      tick();
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    tick();
    check_eq("write_retired", LINE_W'(sb_q.size() + beat_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    tick();
    tick();
    check_eq("rst_read_o",    LINE_W'(read_o),    '0);
    check_eq("rst_write_o",   LINE_W'(write_o),   '0);
    check_eq("rst_resp_o",    LINE_W'(resp_o),    '0);
    check_eq("rst_address_o", LINE_W'(address_o), '0);
    check_eq("rst_line_o",    line_o,             '0);
    check_eq("rst_burst_o",   LINE_W'(burst_o),   '0);
    reset_n = 1'b1;
    tick();

    // Basic contiguous read.
    do_read(32'h1234_5678, {BD, BC, BB, BA}, BEATS, 0, 1'b0);

    // Write with a 2-cycle stall between beat index 1 and 2.
    do_write(32'h0000_ABCD, {BD, BC, BB, BA}, 2, 2);

    // Read and write together: read wins, write_o must stay low.
    no_write = 1'b1;
    do_read(32'h8000_0040, {BA, BB, BC, BD}, 1, 1, 1'b1);
    no_write = 1'b0;

    // Wrap-candidate read: beats C,D,A,B at offset 0x70.
    do_read(32'h0000_0070, {BB, BA, BD, BC}, BEATS, 0, 1'b0);

    // resp_i while idle must not start or complete anything.
    resp_i = 1'b1;
    tick();
    tick();
    resp_i = 1'b0;
    check_eq("idle_resp_i_strobes", LINE_W'({read_o, write_o, resp_o}), '0);

    // Reset after beat 2 of a read aborts without resp_o.
    read_i    = 1'b1;
    address_i = 32'h5555_0000;
    tick();
    resp_i  = 1'b1;
    burst_i = BA;
    tick();
    burst_i = BB;
    tick();
    reset_n = 1'b0;
    resp_i  = 1'b0;
    read_i  = 1'b0;
    tick();
    check_eq("abort_read_o", LINE_W'(read_o), '0);
    check_eq("abort_resp_o", LINE_W'(resp_o), '0);
    check_eq("abort_line_o", line_o, '0);
    reset_n = 1'b1;
    tick();
    check_eq("abort_idle", LINE_W'({read_o, write_o, resp_o}), '0);

    // Recovery read with a stall before the first beat.
    do_read(32'h0F0F_F0F8, {BC, BA, BD, BB}, 0, 3, 1'b0);

    repeat (3) tick();
    check_eq("sb_empty_at_end", LINE_W'(sb_q.size() + beat_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_cacheline_adaptor.md
# param_cacheline_adaptor

Parametrised bridge between the last-level cache and burst-oriented main memory. It moves one LINE_W-bit cache line as LINE_W/BURST_W beats of BURST_W bits. Compared with the fixed 256/64 adaptor it adds per-beat `resp_i` qualification, so memory may stall between beats. It also supports optional critical-beat-first wrapped reads. It sits between the LLC miss/write-back logic and the physical memory port.

## Interface
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width; LINE_W/BURST_W = BEATS, a power of two, at least 2
- ADDR_W, 32, address width
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- line_i  in  LINE_W  write-back data from LLC
- line_o  out  LINE_W  fill data to LLC
- address_i  in  ADDR_W  request byte address
- read_i  in  1  LLC read request
- write_i  in  1  LLC write request
- resp_o  out  1  one-cycle completion pulse to LLC
- burst_i  in  BURST_W  read beat from memory
- burst_o  out  BURST_W  write beat to memory
- address_o  out  ADDR_W  memory address
- read_o  out  1  memory read strobe
- write_o  out  1  memory write strobe
- resp_i  in  1  memory beat acknowledge, one per beat

## Operation
- States: IDLE, RBURST, WBURST, DONE. Beat counter `cnt` is log2(BEATS) bits wide. Beats-accepted counter `n` runs 0..BEATS.
- IDLE: `read_i` takes priority over `write_i`.
  - On read: capture the address and go to RBURST.
  - On write: capture the address and `line_i`, then go to WBURST.
  - Neither asserted: hold.
- Address capture:
  - `address_o` = `address_i` with the low log2(LINE_W/8) bits zeroed.
  - Set `cnt` = 0 and `n` = 0.
- RBURST:
  - `read_o` = 1.
  - On each cycle with `resp_i` = 1, write `burst_i` into line-buffer slice `cnt`, then `cnt++` (mod BEATS) and `n++`.
  - On the cycle with `resp_i` = 1 and `n` = BEATS-1, go to DONE.
- WBURST:
  - `write_o` = 1 and `burst_o` = line-buffer slice `cnt`.
  - On each `resp_i` = 1, advance exactly as in RBURST.
  - Final beat goes to DONE.
- DONE: `resp_o` = 1 for exactly one cycle, then IDLE.
- `line_o` is driven from the line buffer at all times. It is valid from the DONE cycle of a read until the next request is captured.
- `resp_i` while IDLE or DONE is ignored.
- `read_i`/`write_i` while busy are ignored. The LLC holds its request until `resp_o`, and the adaptor does not re-accept the held request in the DONE cycle.
- `cnt` wrap-around is mod BEATS. `n` does not wrap; it saturates the state transition only.

## Timing
- Reset values: `read_o` 0, `write_o` 0, `resp_o` 0, `address_o` 0, `line_o` 0, `burst_o` 0, state IDLE, `cnt` 0.
- Reset asserted mid-burst aborts the transfer and returns to IDLE on the next edge. No `resp_o` is issued.
- Request sampled at edge 0 → `read_o`/`write_o` high from cycle 1.
- Memory latency:
  - First `resp_i` at cycle k, beats contiguous → `resp_o` at cycle k+BEATS, and the strobe drops in that same cycle.
  - Each stalled cycle (`resp_i` = 0) adds one cycle of latency.
- Minimum turnaround is DONE then IDLE: a new request is accepted 2 cycles after the last beat.
- `burst_o` changes only on the edge following an accepted beat.

## Configuration
- `PARAM_CACHELINE_ADAPTOR_WRAP_EN`:
  - Defined: reads are critical-beat-first.
    - Start beat s = `address_i`[log2(LINE_W/8)-1 : log2(BURST_W/8)].
    - `address_o` zeroes only the low log2(BURST_W/8) bits.
    - `cnt` starts at s and wraps, so beat i lands in slice (s+i) mod BEATS.
    - Writes are unchanged (start 0, line-aligned).
  - Undefined: every transfer starts at beat 0 with a line-aligned address.

## Structure
- Shared package `cache_adaptor_pkg` holds the state enum (IDLE, RBURST, WBURST, DONE) and the default width localparams.
- No sub-modules. The single file contains the FSM, counters, and line buffer.

## Test plan
- Reset with `reset_n` = 0 for 2 cycles → all outputs 0, state IDLE.
- Read at 0x1234_5678, `resp_i` for 4 contiguous cycles with beats A,B,C,D (defaults) → `address_o` = 0x1234_5660, `line_o` = {D,C,B,A}, `resp_o` pulses once at cycle k+4.
- Write `line_i` = {D,C,B,A} with `resp_i` stalled 2 cycles between beats 1 and 2 → `burst_o` sequence A,B,C,D, each held until acked, and `resp_o` 1 cycle after beat D.
- `read_i` and `write_i` both asserted → read performed, `write_o` never rises.
- With WRAP_EN, read at 0x…70 with beats C,D,A,B → `line_o` = {D,C,B,A}, `address_o` = 0x…70.
- `reset_n` low after beat 2 of a read → `read_o` 0 next cycle, no `resp_o`. A new read afterwards completes normally.
